out_port_uart_tx: RTL and testbench

//  Receiving end of the CPU output port. Captures each byte the CPU writes with its output

---
 rtl/out_port_uart_tx_pkg.sv | 14 +
 rtl/out_port_uart_tx_if.sv | 24 ++
 rtl/out_port_uart_tx_byte_fifo.sv | 51 +++++
 rtl/out_port_uart_tx.sv | 127 ++++++++++++
 tb/tb_out_port_uart_tx.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/out_port_uart_tx_pkg.sv
// Shared types for the CPU output-port UART transmitter.
// Holds the serialiser state encoding and frame geometry.
package out_port_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/out_port_uart_tx_if.sv
// CPU-side byte strobe plus serial/status outputs of the UART.
// master = CPU/system side, slave = transmitter.
interface out_port_uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          out_strobe;
  logic [7:0]    out_data;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output out_strobe, out_data,
    input  tx, busy, fifo_count, overflow
  );

  modport slave (
    input  out_strobe, out_data,
    output tx, busy, fifo_count, overflow
  );
endinterface

// File: rtl/out_port_uart_tx_byte_fifo.sv
// Byte FIFO with combinational head read.
// A separate count register tells full from empty.
module byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rp];
  assign count  = r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/out_port_uart_tx.sv
// Output-port receiver: buffers CPU bytes and sends them as 8N1 serial.
// Frames run back-to-back while the FIFO holds data.
module out_port_uart_tx
  import out_port_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  out_port_uart_tx_if.slave  bus
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t     r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic          r_ovf;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_last;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;

  assign w_last = (r_timer == TW'(CLKS_PER_BIT - 1));
  assign w_push = bus.out_strobe && !w_full;
  assign w_pop  = !w_empty &&
                  ((r_state == IDLE) || (r_state == STOP && w_last));

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (bus.out_data),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign bus.tx         = r_tx;
  assign bus.busy       = r_busy;
  assign bus.fifo_count = w_count;
  assign bus.overflow   = r_ovf;

  // Full is judged before the edge, so a same-edge pop never rescues a strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ovf <= 1'b0;
    else if (bus.out_strobe && w_full) r_ovf <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_timer <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_last) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        DATA: begin
          if (w_last) begin
            r_timer <= '0;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + 3'd1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        STOP: begin
          if (w_last) begin
            r_timer <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: serial decoder feeds a byte scoreboard,
// plus table-driven FIFO/overflow vectors and timing sequences.
module tb_out_port_uart_tx;
  import out_port_uart_tx_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  out_port_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  out_port_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_frames = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] d;
    bit         acc;
    int         cnt;
    int         ovf;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Serial decoder: samples mid-bit, compares each byte with the queue head
  initial begin
    bit         act;
    int         cnt;
    logic [7:0] sh;
    act = 0;
    cnt = 0;
    sh  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        act = 0;
      end else if (!act) begin
        if (bus.tx === 1'b0) begin
          act = 1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == CPB / 2) begin
          check("start_bit", int'(bus.tx), 0);
        end else if (cnt >= CPB + CPB / 2 && cnt <= 8 * CPB + CPB / 2
                     && (cnt % CPB) == CPB / 2) begin
          sh = {bus.tx, sh[7:1]};
        end else if (cnt == 9 * CPB + CPB / 2) begin
          check("stop_bit", int'(bus.tx), 1);
        end else if (cnt == FRAME_BITS * CPB - 1) begin
          act = 0;
          m_frames++;
          if (sb.size() == 0) check("unexpected_byte", int'(sh), 256);
          else check("byte", int'(sh), int'(sb.pop_front()));
        end
      end
    end
  end

  task automatic drain_busy(input int start, input int want, input string nm);
    int n;
    int guard;
    n = start;
    guard = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.busy) break;
      n++;
      guard++;
      if (guard > 2000) break;
    end
    check(nm, n, want);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t t6[5];
    int   bcnt;
    int   peak;
    int   f0;

    bus.out_strobe = 1'b0;
    bus.out_data   = '0;

    // 1: reset
    repeat (3) @(negedge clk);
    check("rst_tx", int'(bus.tx), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_count", int'(bus.fifo_count), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 2: single byte 0xA5
    bus.out_strobe = 1'b1;
    bus.out_data   = 8'hA5;
    sb.push_back(8'hA5);
    @(posedge clk); #1;
    check("single_tx_n", int'(bus.tx), 1);
    check("single_busy_n", int'(bus.busy), 0);
    check("single_cnt_n", int'(bus.fifo_count), 1);
    @(negedge clk);
    bus.out_strobe = 1'b0;
    @(posedge clk); #1;
    check("single_tx_n1", int'(bus.tx), 0);
    check("single_busy_n1", int'(bus.busy), 1);
    check("single_cnt_n1", int'(bus.fifo_count), 0);
    drain_busy(1, 40, "single_busy_len");
    repeat (3) @(negedge clk);
    check("single_sb_empty", sb.size(), 0);

    // 3: burst of three, back-to-back frames
    bcnt = 0;
    peak = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.out_strobe = 1'b1;
      bus.out_data   = 8'(i);
      sb.push_back(8'(i));
      @(posedge clk); #1;
      if (bus.busy) bcnt++;
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    end
    @(negedge clk);
    bus.out_strobe = 1'b0;
    check("burst_peak", peak, 2);
    drain_busy(bcnt, 3 * FRAME_BITS * CPB, "burst_busy_len");
    repeat (3) @(negedge clk);
    check("burst_sb_empty", sb.size(), 0);

    // 4: overflow table
    tbl[0] = '{8'h10, 1'b1, 1, 0};
    tbl[1] = '{8'h11, 1'b1, 1, 0};
    tbl[2] = '{8'h12, 1'b1, 2, 0};
    tbl[3] = '{8'h13, 1'b1, 3, 0};
    tbl[4] = '{8'h14, 1'b1, 4, 0};
    tbl[5] = '{8'h15, 1'b0, 4, 1};
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.out_strobe = 1'b1;
      bus.out_data   = tbl[i].d;
      if (tbl[i].acc) sb.push_back(tbl[i].d);
      @(posedge clk); #1;
      if (bus.busy) bcnt++;
      check($sformatf("ovf_cnt[%0d]", i), int'(bus.fifo_count), tbl[i].cnt);
      check($sformatf("ovf_flag[%0d]", i), int'(bus.overflow), tbl[i].ovf);
    end
    @(negedge clk);
    bus.out_strobe = 1'b0;
    drain_busy(bcnt, 5 * FRAME_BITS * CPB, "ovf_busy_len");
    repeat (3) @(negedge clk);
    check("ovf_sb_empty", sb.size(), 0);
    check("ovf_sticky", int'(bus.overflow), 1);

    // 5: reset during DATA bit 3 with two bytes queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.out_strobe = 1'b1;
      bus.out_data   = 8'h31 + 8'(i);
      sb.push_back(8'h31 + 8'(i));
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.out_strobe = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    check("mid_busy", int'(bus.busy), 1);
    check("mid_cnt", int'(bus.fifo_count), 2);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", int'(bus.tx), 1);
    check("mid_rst_cnt", int'(bus.fifo_count), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    sb.delete();
    f0 = m_frames;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_no_frames", m_frames, f0);
    check("mid_tx_idle", int'(bus.tx), 1);
    check("mid_ovf_clr", int'(bus.overflow), 0);

    // 6: strobe while full on the same edge as a pop
    for (int i = 0; i < 5; i++) t6[i] = '{8'h20 + 8'(i), 1'b1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.out_strobe = 1'b1;
      bus.out_data   = t6[i].d;
      sb.push_back(t6[i].d);
    end
    @(negedge clk);
    bus.out_strobe = 1'b0;
    check("pp_full", int'(bus.fifo_count), 4);
    repeat (36) @(negedge clk);
    check("pp_full_pre", int'(bus.fifo_count), 4);
    check("pp_ovf_pre", int'(bus.overflow), 0);
    bus.out_strobe = 1'b1;
    bus.out_data   = 8'h25;
    @(negedge clk);
    bus.out_strobe = 1'b0;
    check("pp_cnt", int'(bus.fifo_count), 3);
    check("pp_ovf", int'(bus.overflow), 1);
    check("pp_busy", int'(bus.busy), 1);
    drain_busy(0, 4 * FRAME_BITS * CPB - 1, "pp_busy_len");
    repeat (3) @(negedge clk);
    check("pp_sb_empty", sb.size(), 0);
    check("pp_ovf_sticky", int'(bus.overflow), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
